// File: rtl/alu_serial_responder.sv
// -----------------------------------------------------------------------------
// alu_serial_responder
//
// Bit-serial, multi-cycle ALU acting as the responder end of an ALU request
// channel. A request {opcode, A, B} is accepted in IDLE. One result bit is then
// produced per enabled cycle, LSB first. The finished {cout, out} is offered on
// the response channel. The opcode semantics match the combinational 4-bit ALU,
// so the same checker expressions apply to the response.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   A producer that raises valid holds it, and its payload, stable until that
//   edge. req_ready is high only in IDLE while enable is high and rst_n is
//   released. rsp_valid is high exactly while the FSM is in DONE. The DONE
//   handshake completes regardless of enable.
//
// Parameters:
//   WIDTH     operand/result width in bits (>= 2)
//   CNT_W     bit counter width, derived from WIDTH (do not override)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   global enable; low stalls BUSY and closes req_ready
//   req_valid  in   request present
//   req_ready  out  block can accept a request
//   A, B       in   operands [WIDTH-1:0], sampled on accept only
//   opcode     in   00 add, 01 sub, 10 and, 11 pass A
//   rsp_valid  out  result present
//   rsp_ready  in   consumer takes result (ignored outside DONE)
//   out        out  result bits [WIDTH-1:0]
//   cout       out  add: carry out; sub: borrow; and/pass: 0
//   dbg_state  out  current FSM state encoding (0 IDLE, 1 BUSY, 2 DONE)
//   ovf        out  signed overflow for add/sub, valid with rsp_valid
//                   (present only when ALU_SERIAL_OVF_EN is defined)
//
// Build option:
//   ALU_SERIAL_OVF_EN  adds the ovf output and its tracking register.
// -----------------------------------------------------------------------------
module alu_serial_responder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       opcode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic [1:0]       dbg_state
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state_q;
  state_t             state_d;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cout_q;

  // FSM-produced strobes
  logic               accept;     // request transfer on this edge
  logic               step;       // process one bit on this edge
  logic               last_step;  // processing the MSB on this edge

  // Single-bit slice of the datapath
  logic               bit_a;
  logic               bit_b_raw;
  logic               bit_b;      // b, inverted for subtract
  logic               bit_sum;
  logic               carry_nx;
  logic               res_bit;
  logic               is_arith;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // rst_n is folded in so req_ready reads 0 for the whole time reset is
        // held, not just after the first edge.
        req_ready = enable & rst_n;
        accept    = req_valid & req_ready;
        if (accept) begin
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        step      = enable;
        last_step = enable && (cnt_q == LAST_BIT);
        if (last_step) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // enable does not gate the response handshake.
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One-bit ALU slice operating on bit[cnt_q]
  // ---------------------------------------------------------------------------
  always_comb begin
    is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    bit_a     = a_q[cnt_q];
    bit_b_raw = b_q[cnt_q];
    // Subtraction is a + ~b + 1. The +1 comes from carry_q preset at accept.
    bit_b     = bit_b_raw ^ (op_q == OP_SUB);
    bit_sum   = bit_a ^ bit_b ^ carry_q;
    carry_nx  = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);

    res_bit = 1'b0;
    case (op_q)
      OP_ADD:  res_bit = bit_sum;
      OP_SUB:  res_bit = bit_sum;
      OP_AND:  res_bit = bit_a & bit_b_raw;
      OP_PASS: res_bit = bit_a;
      default: res_bit = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      // Operands are captured here only. Later changes on A/B/opcode are ignored.
      a_q     <= A;
      b_q     <= B;
      op_q    <= opcode;
      res_q   <= '0;
      carry_q <= (opcode == OP_SUB);
      cnt_q   <= '0;
      cout_q  <= 1'b0;
    end else if (step) begin
      res_q[cnt_q] <= res_bit;
      carry_q      <= carry_nx;
      if (last_step) begin
        // Leave the counter at 0 so it is already clean before the next accept.
        cnt_q <= '0;
        case (op_q)
          OP_ADD:  cout_q <= carry_nx;
          OP_SUB:  cout_q <= ~carry_nx;  // no final carry means a borrow
          default: cout_q <= 1'b0;
        endcase
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

`ifdef ALU_SERIAL_OVF_EN
  // Signed overflow is the carry into the MSB XOR the carry out of the MSB.
  // carry_q holds the carry into the bit being processed, so on the MSB step
  // it is the carry-in to the MSB.
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (last_step) begin
      ovf_q <= is_arith & (carry_q ^ carry_nx);
    end
  end

  assign ovf = ovf_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out       = res_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: doc/alu_serial_responder.md
Name: alu_serial_responder

Overview:
- Bit-serial, multi-cycle ALU with a valid/ready request channel and a valid/ready response channel.
- Serves as the responder endpoint for ALU operation requests: accepts {opcode, A, B} from an initiator and computes one bit per cycle.
- Returns {cout, out} with the same opcode semantics as the combinational 4-bit ALU, so the same checker expressions apply to the response.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  global enable; low stalls the block (see Behaviour).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- A  input  WIDTH  operand A, sampled on accept.
- B  input  WIDTH  operand B, sampled on accept.
- opcode  input  2  operation: 00 add, 01 sub, 10 and, 11 pass A.
- rsp_valid  output  1  result present.
- rsp_ready  input  1  consumer takes result.
- out  output  WIDTH  result bits.
- cout  output  1  carry/borrow bit.

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: state=IDLE, req_ready=0 while rst_n low, rsp_valid=0, out=0, cout=0, counter=0, internal operand/carry registers=0.
- FSM states:
  - IDLE: req_ready = enable. Accept on an edge where req_valid && req_ready: latch A, B, opcode; clear the result shift register; set carry_in = 1 for sub, 0 otherwise; counter=0; go to BUSY.
  - BUSY: each edge with enable=1 processes bit[counter]:
    - add: sum = a ^ b ^ c, c' = majority(a, b, c).
    - sub: a + ~b + carry, same sum/carry equations with b inverted.
    - and: a & b.
    - pass: a.
  - Result bit is written at position counter and counter increments. After bit WIDTH-1 is processed, go to DONE.
  - DONE: rsp_valid=1 and out/cout are stable until rsp_ready is sampled high; then go to IDLE with rsp_valid=0 on the next cycle.
- enable=0: in BUSY, counter and datapath hold. In IDLE, req_ready=0. In DONE, rsp_valid is held and the handshake still completes.
- Latency: accept on edge k (enable high throughout) → rsp_valid high after edge k+WIDTH. No request is accepted while BUSY or DONE (req_ready=0), so throughput is at most 1 op per WIDTH+2 cycles.
- cout rules:
  - add: final carry, so {cout,out} = A+B mod 2^(WIDTH+1).
  - sub: cout = ~final carry (borrow), so {cout,out} = (A-B) mod 2^(WIDTH+1); e.g. 3-5 → cout=1, out=1110.
  - and / pass: cout=0.
- Inputs are don't-care except on the accept edge; changing A/B/opcode mid-operation has no effect.
- rsp_ready high outside DONE is ignored.
- Reset mid-operation: asynchronous return to reset values; the in-flight op is discarded and no response is produced.

Optional Feature:
- Macro ALU_SERIAL_OVF_EN.
- Defined: adds output port ovf (1 bit), valid with rsp_valid.
  - add/sub: ovf = signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - and/pass: ovf=0.
  - Reset value 0.
- Undefined: no ovf port and no related logic.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY (A=7, B=9, add) → next sampled values rsp_valid=0, req_ready=0, out=0, cout=0. After release with enable=1, req_ready=1 and no response ever appears.
- Add: A=4'hF, B=4'h1, opcode=00, rsp_ready=1 → rsp_valid exactly 4 edges after accept, cout=1, out=0000. Check that req_ready is 0 during BUSY/DONE.
- Sub: A=3, B=5, opcode=01 → cout=1, out=1110. Also A=9, B=2 → cout=0, out=0111.
- AND/pass: A=1010, B=0110, opcode=10 → out=0010, cout=0. Then opcode=11 → out=1010, cout=0.
- Stall/backpressure: deassert enable for 3 cycles mid-BUSY → rsp_valid delayed by 3 cycles with an identical result. Then hold rsp_ready=0 for 5 cycles → rsp_valid, out, cout stable; no new accept while req_valid is held high.
- 200 random ops with random enable/rsp_ready gaps → every response equals the reference expression for its opcode, in order, with none lost or duplicated. With ALU_SERIAL_OVF_EN: 7+1 add → ovf=1; -8-1 sub → ovf=1.
